fifo_fft_frame_reader: RTL and testbench

// Read-side consumer of the FFT distributed FIFO. On a start pulse it drains exactly FRAME_LEN

---
 rtl/fifo_fft_frame_reader.sv | 166 ++++++++++++++++
 tb/tb_fifo_fft_frame_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fft_frame_reader.sv
// fifo_fft_frame_reader
// Read-side consumer of the FFT distributed FIFO. A start pulse in IDLE drains
// exactly FRAME_LEN words from the FIFO read port and emits them as one
// valid/ready frame with m_tlast on the final word. A 2-entry output buffer
// hides the FIFO read latency (RD_LATENCY 0 = show-ahead, 1 = registered) and
// sustains one word per cycle while m_tready stays high.
//
// Ports
//   rd_clk, rd_rst          clock, asynchronous active-high reset
//   start                   frame request pulse (ignored unless IDLE)
//   busy                    high in RUN / DRAIN / DONE
//   frame_done              one-cycle pulse after the last word is accepted
//   fifo_rd_en              FIFO read enable (never high while fifo_empty)
//   fifo_rd_data            FIFO read data
//   fifo_empty              FIFO empty flag
//   m_tdata/m_tvalid/
//   m_tready/m_tlast        output stream
//   sample_cnt              words accepted downstream in the current frame
module fifo_fft_frame_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 0,
    parameter int FRAME_LEN  = 1024,
    parameter int CNT_W      = $clog2(FRAME_LEN + 1)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [CNT_W-1:0]      sample_cnt
);

    localparam bit               LAT1     = (RD_LATENCY != 0);
    localparam logic [CNT_W-1:0] LEN      = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]                 issued;    // reads issued this frame
    logic [CNT_W-1:0]                 pushed;    // words written into the buffer
    logic                             inflight;  // read issued, data due next cycle
    logic [1:0]                       occ;       // buffer occupancy 0..2
    logic [1:0][DATA_WIDTH-1:0]       buf_data;
    logic [1:0]                       buf_last;
    logic                             rd_ptr;
    logic                             wr_ptr;
    logic                             pop;
    logic                             push;
    logic                             start_acc;
    logic [2:0]                       used_after;

    // ---------------------------------------------------------------
    // Stream side: head entry of the buffer
    // ---------------------------------------------------------------
    assign m_tvalid = (occ != 2'd0);
    assign m_tdata  = buf_data[rd_ptr];
    // Stale last flags may remain in an emptied slot, so qualify with valid.
    assign m_tlast  = buf_last[rd_ptr] & m_tvalid;
    assign pop      = m_tvalid & m_tready;

    // ---------------------------------------------------------------
    // Read issue. Slots committed after this cycle = occ + inflight - pop;
    // a word popped this cycle frees its slot for a read in the same cycle,
    // which is what lets the reader sustain one word per cycle.
    // ---------------------------------------------------------------
    assign used_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = (state == S_RUN) && !fifo_empty && (issued < LEN)
                        && (used_after < 3'd2);

    // With a registered FIFO the word shows up one cycle after the read.
    assign push = LAT1 ? inflight : fifo_rd_en;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    start_acc = 1'b1;
                end
            end
            S_RUN: begin
                // With show-ahead reads the final word can already be accepted
                // in the cycle RUN notices all reads are issued.
                if (issued == LEN) state_nxt = (pop && m_tlast) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && m_tlast) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    // ---------------------------------------------------------------
    // Counters
    // ---------------------------------------------------------------
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            issued     <= '0;
            pushed     <= '0;
            sample_cnt <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= LAT1 && fifo_rd_en;
            if (start_acc) begin
                issued     <= '0;
                pushed     <= '0;
                sample_cnt <= '0;
            end else begin
                if (fifo_rd_en) issued <= issued + CNT_W'(1);
                if (push)       pushed <= pushed + CNT_W'(1);
                if (pop && (sample_cnt != LEN)) sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // 2-entry output buffer. Each word is tagged with its last flag on
    // entry, since the buffer preserves order.
    // ---------------------------------------------------------------
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            buf_data <= '0;
            buf_last <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= fifo_rd_data;
                buf_last[wr_ptr] <= (pushed == LAST_IDX);
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_fft_frame_reader.sv
// Bench: runs an RD_LATENCY=0 and an RD_LATENCY=1 reader side by side on the
// same start/ready/reset stimulus, each with its own FIFO read pointer into a
// shared word store where word k holds value k.
module tb_fifo_fft_frame_reader;

    localparam int DW = 32;
    localparam int FL = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst, start, ready;
    always #5 clk = ~clk;

    logic [1:0]          busy, done, rd_en, empty, vld, last;
    logic [1:0][DW-1:0]  data;
    logic [1:0][CW-1:0]  scnt;
    logic [DW-1:0]       rdata0, rdata1;

    logic [DW-1:0] mem [0:127];
    int rp0 = 0;
    int rp1 = 0;
    int wp  = 0;

    // show-ahead FIFO model
    assign rdata0   = mem[rp0];
    assign empty[0] = (rp0 == wp);
    always @(posedge clk) if (rd_en[0]) rp0 <= rp0 + 1;

    // registered-output FIFO model
    assign empty[1] = (rp1 == wp);
    always @(posedge clk) if (rd_en[1]) begin
        rdata1 <= mem[rp1];
        rp1    <= rp1 + 1;
    end

    fifo_fft_frame_reader #(.DATA_WIDTH(DW), .RD_LATENCY(0), .FRAME_LEN(FL)) dut0 (
        .rd_clk(clk), .rd_rst(rst), .start(start), .busy(busy[0]), .frame_done(done[0]),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rdata0), .fifo_empty(empty[0]),
        .m_tdata(data[0]), .m_tvalid(vld[0]), .m_tready(ready), .m_tlast(last[0]),
        .sample_cnt(scnt[0]));

    fifo_fft_frame_reader #(.DATA_WIDTH(DW), .RD_LATENCY(1), .FRAME_LEN(FL)) dut1 (
        .rd_clk(clk), .rd_rst(rst), .start(start), .busy(busy[1]), .frame_done(done[1]),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rdata1), .fifo_empty(empty[1]),
        .m_tdata(data[1]), .m_tvalid(vld[1]), .m_tready(ready), .m_tlast(last[1]),
        .sample_cnt(scnt[1]));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Monitor (negedge): beat capture and per-cycle protocol checks.
    // Per-frame records clear on reset and on an accepted start.
    // ---------------------------------------------------------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            rd_cnt [2];
    int            acc    [2];
    int            dcnt   [2];
    int            lcnt   [2];
    int            lidx   [2];
    int            first_c[2];
    int            lbeat_c[2];
    int            done_c [2];
    int            start_c;
    logic [DW-1:0] beat   [2][0:15];
    logic          hold   [2];
    logic [DW-1:0] hd     [2];
    logic          hl     [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || (start && !busy[d])) begin
                rd_cnt[d] = 0; acc[d] = 0; dcnt[d] = 0; lcnt[d] = 0; lidx[d] = -1;
                first_c[d] = -1; lbeat_c[d] = -1; done_c[d] = -1; hold[d] = 1'b0;
                if (!rst) start_c = cyc;
            end else begin
                int p;
                p = int'(vld[d] & ready);
                // buffered + in-flight words after this cycle never exceed 2
                chk("occ_bound", ((rd_cnt[d] - acc[d] + int'(rd_en[d]) - p) <= 2), 1);
                chk("rd_while_empty", rd_en[d] & empty[d], 0);
                if (hold[d]) begin
                    chk("hold_valid", vld[d], 1);
                    chk("hold_data", data[d], hd[d]);
                    chk("hold_last", last[d], hl[d]);
                end
                hold[d] = vld[d] & ~ready;
                hd[d]   = data[d];
                hl[d]   = last[d];
                if (rd_en[d]) rd_cnt[d]++;
                if (p != 0) begin
                    if (acc[d] < 16) beat[d][acc[d]] = data[d];
                    if (acc[d] == 0) first_c[d] = cyc;
                    lbeat_c[d] = cyc;
                    if (last[d]) begin lcnt[d]++; lidx[d] = acc[d]; end
                    acc[d]++;
                end
                if (done[d]) begin dcnt[d]++; done_c[d] = cyc; end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
    task automatic wait_frame(input int budget, input int mode);
        logic [3:0] pat;
        pat = 4'b1001;
        for (int k = 0; k < budget; k++) begin
            if (dcnt[0] >= 1 && dcnt[1] >= 1) break;
            ready = (mode == 1) ? pat[k % 4] : 1'b1;
            tick();
        end
        ready = 1'b1;
        chk("frame_timeout", (dcnt[0] >= 1 && dcnt[1] >= 1), 1);
    endtask

    task automatic check_frame(input int base0, input int base1, input bit nogap);
        for (int d = 0; d < 2; d++) begin
            int b;
            b = (d == 0) ? base0 : base1;
            chk("beat_count", acc[d], FL);
            for (int i = 0; i < FL; i++) chk("beat_data", beat[d][i], b + i);
            chk("last_count", lcnt[d], 1);
            chk("last_index", lidx[d], FL - 1);
            chk("rd_en_count", rd_cnt[d], FL);
            chk("done_count", dcnt[d], 1);
            chk("done_after_last", done_c[d] - lbeat_c[d], 1);
            if (nogap) chk("no_gaps", lbeat_c[d] - first_c[d], FL - 1);
            chk("sample_cnt_end", scnt[d], FL);
            chk("busy_end", busy[d], 0);
        end
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
            chk("rst_rd_en", rd_en[d], 0);
            chk("rst_valid", vld[d], 0);
            chk("rst_last", last[d], 0);
            chk("rst_data", data[d], 0);
            chk("rst_sample_cnt", scnt[d], 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    // ---------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------
    initial begin
        int b0, b1;
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        for (int k = 0; k < 128; k++) mem[k] = DW'(k);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        tick();

        // T1/T2: words 0..9 available, ready high
        wp = 10;
        pulse_start();
        wait_frame(60, 0);
        check_frame(0, 0, 1);
        // first beat two negedges after start is seen (show-ahead), one more registered
        chk("first_beat_lat0", first_c[0] - start_c, 2);
        chk("first_beat_lat1", first_c[1] - start_c, 3);
        chk("left_in_fifo0", wp - rp0, 2);
        chk("left_in_fifo1", wp - rp1, 2);
        tick();

        // T3: ready 1,0,0,1 back-pressure, frame is words 8..15
        wp = 16;
        pulse_start();
        wait_frame(200, 1);
        check_frame(8, 8, 0);
        tick();

        // T4: only 4 words, then a 25-cycle dry spell, then the rest
        wp = 20;
        pulse_start();
        repeat (25) tick();
        for (int d = 0; d < 2; d++) begin
            chk("gap_beats", acc[d], 4);
            chk("gap_valid", vld[d], 0);
            chk("gap_busy", busy[d], 1);
        end
        wp = 24;
        wait_frame(100, 0);
        check_frame(16, 16, 0);
        tick();

        // T5: second start during RUN must be ignored
        wp = 40;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_frame(60, 0);
        check_frame(24, 24, 1);
        repeat (20) tick();
        chk("t5_idle0", busy[0], 0);
        chk("t5_idle1", busy[1], 0);
        chk("t5_rp0", rp0, 32);
        chk("t5_rp1", rp1, 32);
        chk("t5_scnt0", scnt[0], FL);
        chk("t5_scnt1", scnt[1], FL);

        // T6: reset after four beats, then a fresh frame
        wp = 100;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            if (acc[0] >= 4) break;
            tick();
        end
        chk("t6_reach_word4", (acc[0] >= 4), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        tick();
        rst = 1'b0;
        tick();
        b0 = rp0;
        b1 = rp1;
        pulse_start();
        wait_frame(60, 0);
        check_frame(b0, b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
